// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
//  Shared definitions for the program-counter sequencer: sequencing op
//  encodings driven by the instruction decoder and the run/halt FSM states.
//  Imported by pc_sequencer and ra_stack.
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

    // Sequencing op encodings from the decoder; 6 and 7 are reserved and
    // behave as OP_SEQ.
    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5
    } op_e;

    // Run/halt FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_ra_stack.sv
// ---------------------------------------------------------------------------
// ra_stack
//  Return-address LIFO, DEPTH entries of AW bits.
//  Ports:
//   clk        in   clock, rising edge
//   clear      in   synchronous active-high clear (empties the stack)
//   push       in   write push_data on top (ignored when full)
//   pop        in   discard top entry (ignored when empty)
//   push_data  in   AW-bit value to push
//   top        out  AW-bit current top entry (undefined content when empty)
//   full       out  occupancy == DEPTH
//   empty      out  occupancy == 0
//   count      out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ra_stack
    import pc_sequencer_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              push_data,
    output logic [AW-1:0]              top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [PW-1:0] top_idx_s;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == {CW{1'b0}});
    assign count = cnt_q;
    assign top   = mem_q[top_idx_s];

    // Top-of-stack index; wraps harmlessly when empty since top is unused then.
    always_comb begin
        top_idx_s = PW'(cnt_q - CNT_ONE);
    end

    // Next stack contents and occupancy; overflow/underflow requests are dropped.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push && !full) begin
            mem_d[cnt_q[PW-1:0]] = push_data;
            cnt_d                = cnt_q + CNT_ONE;
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stack storage and pointer registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {AW{1'b0}};
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//  Next-address controller for the program counter. Every cycle Next_PC is
//  formed combinationally from PC, Op, Target, Cond, Stall, the FSM state and
//  the return-stack top; the PC register loads it on every rising Clk.
//  Ports:
//   Clk        in   system clock
//   Clear      in   synchronous active-high reset
//   PC         in   current PC value
//   Start      in   leave IDLE/HALT (ignored in RUN)
//   Stall      in   hold PC this cycle (only honoured in RUN)
//   Op         in   sequencing op (see pc_sequencer_pkg)
//   Target     in   absolute target (JMP/CALL) or signed offset (BR)
//   Cond       in   branch condition for BR
//   Next_PC    out  value loaded into PC at next edge (combinational)
//   Running    out  FSM in RUN (registered)
//   Halted     out  FSM in HALT (registered)
//   Stack_Err  out  sticky CALL-on-full / RET-on-empty flag (registered)
//   Depth      out  return-stack occupancy (registered)
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          Clk,
    input  logic          Clear,
    input  logic [AW-1:0] PC,
    input  logic          Start,
    input  logic          Stall,
    input  logic [2:0]    Op,
    input  logic [AW-1:0] Target,
    input  logic          Cond,
    output logic [AW-1:0] Next_PC,
    output logic          Running,
    output logic          Halted,
    output logic          Stack_Err,
    output logic [2:0]    Depth
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q;
    state_e        state_d;
    logic          stack_err_q;
    logic          stack_err_d;
    logic          running_q;
    logic          running_d;
    logic          halted_q;
    logic          halted_d;

    logic [AW-1:0] next_pc_s;
    logic [AW-1:0] pc_inc_s;
    logic          push_s;
    logic          pop_s;
    logic [AW-1:0] top_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;

    assign pc_inc_s  = PC + PC_ONE;
    assign Next_PC   = next_pc_s;
    assign Running   = running_q;
    assign Halted    = halted_q;
    assign Stack_Err = stack_err_q;
    assign Depth     = 3'(count_s);

    ra_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ra_stack (
        .clk       (Clk),
        .clear     (Clear),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (top_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Next-state, Next_PC and stack control; Clear forces Next_PC to zero.
    always_comb begin
        state_d     = state_q;
        stack_err_d = stack_err_q;
        next_pc_s   = PC;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (Clear) begin
            next_pc_s = {AW{1'b0}};
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First op is evaluated only once the FSM is in RUN.
                    if (Start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (Stall) begin
                        next_pc_s = PC;
                    end else begin
                        case (Op)
                            OP_SEQ: next_pc_s = pc_inc_s;
                            OP_JMP: next_pc_s = Target;
                            OP_BR: begin
                                // Offset is two's complement; modular add covers negatives.
                                if (Cond) begin
                                    next_pc_s = pc_inc_s + Target;
                                end else begin
                                    next_pc_s = pc_inc_s;
                                end
                            end
                            OP_CALL: begin
                                if (!full_s) begin
                                    push_s    = 1'b1;
                                    next_pc_s = Target;
                                end else begin
                                    stack_err_d = 1'b1;
                                    state_d     = ST_HALT;
                                end
                            end
                            OP_RET: begin
                                if (!empty_s) begin
                                    pop_s     = 1'b1;
                                    next_pc_s = top_s;
                                end else begin
                                    stack_err_d = 1'b1;
                                    state_d     = ST_HALT;
                                end
                            end
                            OP_HALT: state_d = ST_HALT;
                            default: next_pc_s = pc_inc_s;
                        endcase
                    end
                end
                ST_HALT: begin
                    // Resuming steps past the instruction that halted.
                    if (Start) begin
                        state_d   = ST_RUN;
                        next_pc_s = pc_inc_s;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    // FSM, sticky error and status output registers.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q     <= ST_IDLE;
            stack_err_q <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stack_err_q <= stack_err_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

endmodule
